// File: rtl/hex_input_pkg.sv
// Shared types and constants for the hex_input debug data-entry block.
package hex_input_pkg;

    typedef enum logic {
        ARM = 1'b0,
        RUN = 1'b1
    } top_state_t;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } db_state_t;

    localparam int MAX_DIGITS = 8;
    localparam int NUM_SW     = 16;
    localparam int BTN_DEL    = 16;
    localparam int BTN_CLR    = 17;
    localparam int BTN_ENT    = 18;
    localparam int NUM_RAW    = 19;

    // Index of the lowest set bit; 0 when none is set (callers gate with |v).
    function automatic logic [3:0] lowest_set(input logic [NUM_SW-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [31:0] shift_in_digit(input logic [31:0] word,
                                                   input logic [3:0]  digit);
        return {word[27:0], digit};
    endfunction

endpackage

// File: rtl/hex_input_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw board input.
module debounce
    import hex_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_r;
    logic            sync2_r;
    db_state_t       state_r;
    db_state_t       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic            level_r;
    logic            level_s;
    logic            changed_r;
    logic            changed_s;

    // State, counter, level and strobe registers including the synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            state_r   <= STABLE;
            cnt_r     <= '0;
            level_r   <= 1'b0;
            changed_r <= 1'b0;
        end else begin
            sync1_r   <= raw;
            sync2_r   <= sync1_r;
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            level_r   <= level_s;
            changed_r <= changed_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            STABLE: begin
                if (sync2_r != level_r) state_s = SETTLING;
                else                    state_s = STABLE;
            end
            SETTLING: begin
                if (sync2_r == level_r)      state_s = STABLE;
                else if (cnt_r == CNT_LAST)  state_s = STABLE;
                else                         state_s = SETTLING;
            end
            default: state_s = STABLE;
        endcase
    end

    // Counter/level/strobe next values; the first mismatch cycle counts as one.
    always_comb begin
        cnt_s     = cnt_r;
        level_s   = level_r;
        changed_s = 1'b0;
        case (state_r)
            STABLE: begin
                if (sync2_r != level_r) cnt_s = CNT_W'(1);
                else                    cnt_s = '0;
            end
            SETTLING: begin
                if (sync2_r == level_r) begin
                    cnt_s = '0;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_s     = '0;
                    level_s   = ~level_r;
                    changed_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                cnt_s = '0;
            end
        endcase
    end

    assign level   = level_r;
    assign changed = changed_r;

endmodule

// File: rtl/hex_input.sv
// Debug hex entry: debounced switches/buttons build a 32-bit word published on enter.
module hex_input
    import hex_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        btn_del,
    input  logic        btn_clr,
    input  logic        btn_ent,
    output logic [31:0] edit_data,
    output logic [3:0]  digit_count,
    output logic [31:0] data_out,
    output logic        data_valid
);

    // ARM spans the reset cycle plus DEBOUNCE_CYCLES+2 cycles, so a strobe from
    // an input held high through reset lands while events are still discarded.
    localparam int ARM_W = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(DEBOUNCE_CYCLES + 2);
    localparam logic [3:0] COUNT_MAX = 4'(MAX_DIGITS);

    logic [NUM_RAW-1:0] raw_s;
    logic [NUM_RAW-1:0] level_s;
    logic [NUM_RAW-1:0] changed_s;

    assign raw_s = {btn_ent, btn_clr, btn_del, sw};

    genvar g;
    generate
        for (g = 0; g < NUM_RAW; g++) begin : g_db
            debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk     (clk),
                .rst     (rst),
                .raw     (raw_s[g]),
                .level   (level_s[g]),
                .changed (changed_s[g])
            );
        end
    endgenerate

    top_state_t       state_r;
    top_state_t       state_s;
    logic [ARM_W-1:0] arm_cnt_r;
    logic [31:0]      edit_r;
    logic [31:0]      edit_s;
    logic [3:0]       count_r;
    logic [3:0]       count_s;
    logic [31:0]      data_out_r;
    logic [31:0]      data_out_s;
    logic             valid_r;
    logic             valid_s;

    logic [NUM_SW-1:0] sw_evt_s;
    logic              clr_evt_s;
    logic              ent_evt_s;
    logic              del_evt_s;

    assign sw_evt_s  = changed_s[NUM_SW-1:0];
    assign clr_evt_s = changed_s[BTN_CLR] & level_s[BTN_CLR];
    assign ent_evt_s = changed_s[BTN_ENT] & level_s[BTN_ENT];
    assign del_evt_s = changed_s[BTN_DEL] & level_s[BTN_DEL];

    // State register, ARM timer and edit/publish registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ARM;
            arm_cnt_r  <= '0;
            edit_r     <= 32'h0000_0000;
            count_r    <= 4'd0;
            data_out_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            arm_cnt_r  <= (state_r == ARM) ? arm_cnt_r + ARM_W'(1) : arm_cnt_r;
            edit_r     <= edit_s;
            count_r    <= count_s;
            data_out_r <= data_out_s;
            valid_r    <= valid_s;
        end
    end

    // Next-state decode: ARM runs out its timer, RUN holds until reset.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ARM: begin
                if (arm_cnt_r == ARM_LAST) state_s = RUN;
                else                       state_s = ARM;
            end
            RUN:     state_s = RUN;
            default: state_s = ARM;
        endcase
    end

    // One action per cycle in priority order clr > ent > del > digit.
    always_comb begin
        edit_s     = edit_r;
        count_s    = count_r;
        data_out_s = data_out_r;
        valid_s    = 1'b0;
        case (state_r)
            RUN: begin
                if (clr_evt_s) begin
                    edit_s  = 32'h0000_0000;
                    count_s = 4'd0;
                end else if (ent_evt_s) begin
                    data_out_s = edit_r;
                    valid_s    = 1'b1;
                    edit_s     = 32'h0000_0000;
                    count_s    = 4'd0;
                end else if (del_evt_s) begin
                    if (count_r != 4'd0) begin
                        edit_s  = edit_r >> 4;
                        count_s = count_r - 4'd1;
                    end else begin
                        edit_s  = edit_r;
                        count_s = count_r;
                    end
                end else if (|sw_evt_s) begin
                    edit_s  = shift_in_digit(edit_r, lowest_set(sw_evt_s));
                    count_s = (count_r == COUNT_MAX) ? COUNT_MAX : count_r + 4'd1;
                end else begin
                    edit_s = edit_r;
                end
            end
            default: begin
                edit_s = edit_r;
            end
        endcase
    end

    assign edit_data   = edit_r;
    assign digit_count = count_r;
    assign data_out    = data_out_r;
    assign data_valid  = valid_r;

endmodule

// File: tb/tb_hex_input.sv
// Directed self-checking bench for hex_input with DEBOUNCE_CYCLES=4.
module tb_hex_input;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw = 16'h0000;
    logic        btn_del = 1'b0;
    logic        btn_clr = 1'b0;
    logic        btn_ent = 1'b0;
    logic [31:0] edit_data;
    logic [3:0]  digit_count;
    logic [31:0] data_out;
    logic        data_valid;

    int total = 0;
    int bad   = 0;

    hex_input #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .btn_del     (btn_del),
        .btn_clr     (btn_clr),
        .btn_ent     (btn_ent),
        .edit_data   (edit_data),
        .digit_count (digit_count),
        .data_out    (data_out),
        .data_valid  (data_valid)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle(input int i);
        sw[i] = ~sw[i];
        tick(10);
    endtask

    task automatic press_clr();
        btn_clr = 1'b1;
        tick(10);
        btn_clr = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        sw[3] = 1'b1;
        rst   = 1'b1;
        tick(3);
        total++;
        if (edit_data !== 32'h0 || digit_count !== 4'd0 || data_out !== 32'h0 || data_valid !== 1'b0) begin
            $display("FAIL reset_values: edit=%h count=%0d out=%h valid=%b, want all 0", edit_data, digit_count, data_out, data_valid);
            bad++;
        end
        rst = 1'b0;
        tick(20);
        total++;
        if (edit_data !== 32'h0 || digit_count !== 4'd0) begin
            $display("FAIL arm_absorb: edit=%h count=%0d, want 0/0", edit_data, digit_count);
            bad++;
        end
        sw[3] = 1'b0;
        tick(10);
        total++;
        if (edit_data !== 32'h3 || digit_count !== 4'd1) begin
            $display("FAIL sw3_release: edit=%h count=%0d, want 3/1", edit_data, digit_count);
            bad++;
        end
        press_clr();
        total++;
        if (edit_data !== 32'h0 || digit_count !== 4'd0) begin
            $display("FAIL clear: edit=%h count=%0d, want 0/0", edit_data, digit_count);
            bad++;
        end
    endtask

    task automatic test_digits();
        logic [31:0] exp_prev;
        logic [31:0] exp_new;
        int          idx [3];
        idx[0] = 1; idx[1] = 2; idx[2] = 10;
        exp_prev = 32'h0;
        for (int k = 0; k < 3; k++) begin
            exp_new = {exp_prev[27:0], 4'(idx[k])};
            sw[idx[k]] = ~sw[idx[k]];
            tick(6);
            total++;
            if (edit_data !== exp_prev) begin
                $display("FAIL digit_early_%0d: edit=%h, want %h", k, edit_data, exp_prev);
                bad++;
            end
            tick(1);
            total++;
            if (edit_data !== exp_new || digit_count !== 4'(k + 1)) begin
                $display("FAIL digit_at7_%0d: edit=%h count=%0d, want %h/%0d", k, edit_data, digit_count, exp_new, k + 1);
                bad++;
            end
            tick(3);
            exp_prev = exp_new;
        end
        total++;
        if (edit_data !== 32'h0000_012A || digit_count !== 4'd3) begin
            $display("FAIL digits_final: edit=%h count=%0d, want 0000012a/3", edit_data, digit_count);
            bad++;
        end
    endtask

    task automatic test_bounce();
        press_clr();
        for (int k = 0; k < 10; k++) begin
            sw[5] = ~sw[5];
            tick(2);
        end
        sw[5] = 1'b1;
        tick(12);
        total++;
        if (edit_data !== 32'h5 || digit_count !== 4'd1) begin
            $display("FAIL bounce: edit=%h count=%0d, want 5/1", edit_data, digit_count);
            bad++;
        end
    endtask

    task automatic test_overflow_del();
        press_clr();
        for (int k = 1; k <= 9; k++) toggle(k);
        total++;
        if (edit_data !== 32'h2345_6789 || digit_count !== 4'd8) begin
            $display("FAIL nine_digits: edit=%h count=%0d, want 23456789/8", edit_data, digit_count);
            bad++;
        end
        btn_del = 1'b1;
        tick(10);
        btn_del = 1'b0;
        tick(8);
        total++;
        if (edit_data !== 32'h0234_5678 || digit_count !== 4'd7) begin
            $display("FAIL delete: edit=%h count=%0d, want 02345678/7", edit_data, digit_count);
            bad++;
        end
    endtask

    task automatic test_enter();
        int d [8];
        d[0] = 13; d[1] = 14; d[2] = 10; d[3] = 13;
        d[4] = 11; d[5] = 14; d[6] = 14; d[7] = 15;
        press_clr();
        for (int k = 0; k < 8; k++) toggle(d[k]);
        total++;
        if (edit_data !== 32'hDEAD_BEEF || digit_count !== 4'd8) begin
            $display("FAIL deadbeef_entry: edit=%h count=%0d, want deadbeef/8", edit_data, digit_count);
            bad++;
        end
        btn_ent = 1'b1;
        tick(6);
        total++;
        if (data_valid !== 1'b0) begin
            $display("FAIL ent_early: valid=%b, want 0", data_valid);
            bad++;
        end
        tick(1);
        total++;
        if (data_valid !== 1'b1 || data_out !== 32'hDEAD_BEEF || edit_data !== 32'h0 || digit_count !== 4'd0) begin
            $display("FAIL ent_publish: valid=%b out=%h edit=%h count=%0d, want 1/deadbeef/0/0", data_valid, data_out, edit_data, digit_count);
            bad++;
        end
        tick(1);
        total++;
        if (data_valid !== 1'b0 || data_out !== 32'hDEAD_BEEF) begin
            $display("FAIL ent_one_cycle: valid=%b out=%h, want 0/deadbeef", data_valid, data_out);
            bad++;
        end
        btn_ent = 1'b0;
        tick(8);
    endtask

    task automatic test_clr_ent_same();
        toggle(1);
        btn_clr = 1'b1;
        btn_ent = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            total++;
            if (data_valid !== 1'b0) begin
                $display("FAIL clr_ent_valid_%0d: valid=%b, want 0", k, data_valid);
                bad++;
            end
        end
        total++;
        if (edit_data !== 32'h0 || digit_count !== 4'd0 || data_out !== 32'hDEAD_BEEF) begin
            $display("FAIL clr_ent_state: edit=%h count=%0d out=%h, want 0/0/deadbeef", edit_data, digit_count, data_out);
            bad++;
        end
        btn_clr = 1'b0;
        btn_ent = 1'b0;
        tick(8);
    endtask

    task automatic test_empty();
        btn_del = 1'b1;
        tick(10);
        btn_del = 1'b0;
        tick(8);
        total++;
        if (edit_data !== 32'h0 || digit_count !== 4'd0) begin
            $display("FAIL del_at_zero: edit=%h count=%0d, want 0/0", edit_data, digit_count);
            bad++;
        end
        btn_ent = 1'b1;
        tick(7);
        total++;
        if (data_valid !== 1'b1 || data_out !== 32'h0) begin
            $display("FAIL ent_empty: valid=%b out=%h, want 1/00000000", data_valid, data_out);
            bad++;
        end
        btn_ent = 1'b0;
        tick(8);
    endtask

    task automatic test_same_cycle_sw();
        sw[2] = ~sw[2];
        sw[7] = ~sw[7];
        tick(10);
        total++;
        if (edit_data !== 32'h2 || digit_count !== 4'd1) begin
            $display("FAIL same_cycle: edit=%h count=%0d, want 2/1", edit_data, digit_count);
            bad++;
        end
        toggle(7);
        total++;
        if (edit_data !== 32'h27 || digit_count !== 4'd2) begin
            $display("FAIL lost_level_kept: edit=%h count=%0d, want 27/2", edit_data, digit_count);
            bad++;
        end
    endtask

    task automatic test_rst_mid();
        sw[4] = ~sw[4];
        tick(4);
        rst = 1'b1;
        tick(1);
        total++;
        if (edit_data !== 32'h0 || digit_count !== 4'd0 || data_out !== 32'h0 || data_valid !== 1'b0) begin
            $display("FAIL rst_mid: edit=%h count=%0d out=%h valid=%b, want all 0", edit_data, digit_count, data_out, data_valid);
            bad++;
        end
        rst = 1'b0;
        tick(15);
        total++;
        if (edit_data !== 32'h0 || digit_count !== 4'd0) begin
            $display("FAIL rearm_absorb: edit=%h count=%0d, want 0/0", edit_data, digit_count);
            bad++;
        end
        toggle(6);
        total++;
        if (edit_data !== 32'h6 || digit_count !== 4'd1) begin
            $display("FAIL after_rearm: edit=%h count=%0d, want 6/1", edit_data, digit_count);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_bounce();
        test_overflow_del();
        test_enter();
        test_clr_ent_same();
        test_empty();
        test_same_cycle_sw();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
